// File: rtl/mem_fetch_dr_encoder_pkg.sv
// Shared dual-rail definitions for the memory fetch encoder and the demux benches.
// Holds the FSM state type, the NULL spacer and the single-bit encoder.
package mem_fetch_dr_encoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_NULLW,
        ST_HOLD,
        ST_ERR
    } state_e;

    typedef struct packed {
        logic t;
        logic f;
    } dr_bit_t;

    localparam dr_bit_t DR_NULL = '{t: 1'b0, f: 1'b0};

    // Valid codes are 10 (one) and 01 (zero); 11 is never produced.
    function automatic dr_bit_t dr_encode(input logic b);
        dr_bit_t r;
        r.t = b;
        r.f = ~b;
        return r;
    endfunction

endpackage

// File: rtl/dr_sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
module dr_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mem_fetch_dr_encoder.sv
// Converts single-rail memory words into DATA/NULL dual-rail wavefronts for the
// demux, paced by a synchronized completion signal and guarded by a watchdog.
module mem_fetch_dr_encoder
    import mem_fetch_dr_encoder_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NULL_MIN = 2,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             mem_sel,
    output logic             ph0_t,
    output logic             ph0_f,
    output logic [WIDTH-1:0] d_t,
    output logic [WIDTH-1:0] d_f,
    input  logic             comp,
    output logic             busy,
    output logic             timeout_err
);

    localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned HOLD_W = $clog2(NULL_MIN + 1);

    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]   WD_MAX    = WD_W'(TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(NULL_MIN - 1);

    state_e              state_q;
    logic                rdy_q;
    dr_bit_t             ph0_q;
    logic [WIDTH-1:0]    dt_q;
    logic [WIDTH-1:0]    df_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [WD_W-1:0]     wd_q;
    logic                err_q;

    logic                comp_s;
    logic [WIDTH-1:0]    enc_t;
    logic [WIDTH-1:0]    enc_f;
    dr_bit_t             bit_enc;
    logic                wd_expire;

    dr_sync2 u_comp_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (comp),
        .q_o   (comp_s)
    );

    always_comb begin
        enc_t   = '0;
        enc_f   = '0;
        bit_enc = DR_NULL;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bit_enc  = dr_encode(mem_data[i]);
            enc_t[i] = bit_enc.t;
            enc_f[i] = bit_enc.f;
        end
    end

    assign wd_expire = (wd_q == WD_LAST);

    // rdy_q is the registered "idle and out of reset" flag; gating with comp_s
    // keeps a word from being offered while the previous NULL is not yet seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            ph0_q   <= DR_NULL;
            dt_q    <= '0;
            df_q    <= '0;
            hold_q  <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!rdy_q) begin
                        rdy_q <= 1'b1;
                    end else if (mem_valid && !comp_s) begin
                        state_q <= ST_DATA;
                        rdy_q   <= 1'b0;
                        ph0_q   <= dr_encode(mem_sel);
                        dt_q    <= enc_t;
                        df_q    <= enc_f;
                        wd_q    <= '0;
                    end
                end
                ST_DATA: begin
                    if (comp_s) begin
                        state_q <= ST_NULLW;
                        ph0_q   <= DR_NULL;
                        dt_q    <= '0;
                        df_q    <= '0;
                        wd_q    <= '0;
                    end else if (wd_expire) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                        wd_q    <= WD_MAX;
                        ph0_q   <= DR_NULL;
                        dt_q    <= '0;
                        df_q    <= '0;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                ST_NULLW: begin
                    if (!comp_s) begin
                        state_q <= ST_HOLD;
                        hold_q  <= HOLD_LOAD;
                    end else if (wd_expire) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                        wd_q    <= WD_MAX;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                ST_HOLD: begin
                    // Leave as the count reaches zero so the next word can be
                    // accepted NULL_MIN cycles after completion returns low.
                    if (hold_q <= HOLD_W'(1)) begin
                        state_q <= ST_IDLE;
                        rdy_q   <= 1'b1;
                        hold_q  <= '0;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                ST_ERR: begin
                    state_q <= ST_ERR;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ph0_q   <= DR_NULL;
                    dt_q    <= '0;
                    df_q    <= '0;
                end
            endcase
        end
    end

    assign mem_ready   = rdy_q & ~comp_s;
    assign ph0_t       = ph0_q.t;
    assign ph0_f       = ph0_q.f;
    assign d_t         = dt_q;
    assign d_f         = df_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_mem_fetch_dr_encoder.sv
// Self-checking bench for mem_fetch_dr_encoder: directed and random words against
// an arithmetic dual-rail model plus protocol timing derived from the parameters.
module tb_mem_fetch_dr_encoder;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned NULL_MIN = 2;
    localparam int unsigned TIMEOUT  = 16;
    localparam int unsigned SYNC     = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             mem_valid;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_data;
    logic             mem_sel;
    logic             ph0_t;
    logic             ph0_f;
    logic [WIDTH-1:0] d_t;
    logic [WIDTH-1:0] d_f;
    logic             comp;
    logic             busy;
    logic             timeout_err;

    int checks = 0;
    int errors = 0;

    mem_fetch_dr_encoder #(
        .WIDTH    (WIDTH),
        .NULL_MIN (NULL_MIN),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_data    (mem_data),
        .mem_sel     (mem_sel),
        .ph0_t       (ph0_t),
        .ph0_f       (ph0_f),
        .d_t         (d_t),
        .d_f         (d_f),
        .comp        (comp),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: a word drives t = value, f = complement; phase 1 -> (1,0), 0 -> (0,1).
    task automatic chk_data(input string tag, input logic [WIDTH-1:0] w, input logic s);
        logic [WIDTH-1:0] exp_f;
        exp_f = ~w;
        chk({tag, "_dt"},   32'(d_t),   32'(w));
        chk({tag, "_df"},   32'(d_f),   32'(exp_f));
        chk({tag, "_ph0t"}, 32'(ph0_t), 32'(s));
        chk({tag, "_ph0f"}, 32'(ph0_f), 32'(!s));
    endtask

    task automatic chk_null(input string tag);
        chk({tag, "_null"}, 32'({ph0_t, ph0_f, d_t, d_f}), 32'(0));
    endtask

    // Every pair legal, and either every pair NULL or every pair DATA.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("pair_11", 32'((|(d_t & d_f)) || (ph0_t && ph0_f)), 32'(0));
            chk("partial_mix",
                32'((((d_t | d_f) == '0) && !(ph0_t || ph0_f)) ||
                    (((d_t | d_f) == '1) && (ph0_t ^ ph0_f))), 32'(1));
        end
    end

    task automatic accept_word(input string tag, input logic [WIDTH-1:0] w, input logic s);
        mem_data  = w;
        mem_sel   = s;
        mem_valid = 1'b1;
        chk({tag, "_ready"}, 32'(mem_ready), 32'(1));
        tick();
        mem_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'(1));
        chk_data(tag, w, s);
    endtask

    task automatic finish_word(input string tag, input logic [WIDTH-1:0] w, input logic s);
        int n;
        mem_data = WIDTH'($urandom);
        mem_sel  = 1'($urandom);
        comp     = 1'b1;
        for (int k = 0; k < int'(SYNC); k++) begin
            tick();
            chk_data({tag, "_hold"}, w, s);
        end
        tick();
        chk_null({tag, "_after_comp"});
        chk({tag, "_ready_nullw"}, 32'(mem_ready), 32'(0));
        comp = 1'b0;
        n = 0;
        while (mem_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (mem_ready !== 1'b1) chk_null({tag, "_nullhold"});
        end
        chk({tag, "_rearm_latency"}, 32'(n), 32'(SYNC + NULL_MIN));
        chk({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    task automatic do_reset(input string tag);
        comp      = 1'b0;
        mem_valid = 1'b0;
        rst       = 1'b1;
        #1;
        chk({tag, "_rails"}, 32'({ph0_t, ph0_f, d_t, d_f}), 32'(0));
        chk({tag, "_ready"}, 32'(mem_ready), 32'(0));
        chk({tag, "_busy"},  32'(busy), 32'(0));
        chk({tag, "_err"},   32'(timeout_err), 32'(0));
        tick();
        rst = 1'b0;
        chk({tag, "_ready_at_release"}, 32'(mem_ready), 32'(0));
        tick();
        chk({tag, "_ready_after_1"}, 32'(mem_ready), 32'(1));
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        logic             s;

        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_data  = '0;
        mem_sel   = 1'b0;
        comp      = 1'b0;
        #3;
        do_reset("por");

        accept_word("a5", 8'hA5, 1'b0);
        finish_word("a5", 8'hA5, 1'b0);

        accept_word("z0", 8'h00, 1'b1);
        finish_word("z0", 8'h00, 1'b1);

        accept_word("b2b1", 8'h01, 1'b0);
        finish_word("b2b1", 8'h01, 1'b0);
        accept_word("b2b2", 8'h80, 1'b1);
        finish_word("b2b2", 8'h80, 1'b1);

        for (int i = 0; i < 8; i++) begin
            w = WIDTH'($urandom);
            s = 1'($urandom);
            accept_word("rnd", w, s);
            finish_word("rnd", w, s);
        end

        // Completion still high from the previous cycle blocks a new word.
        comp = 1'b1;
        tick();
        tick();
        mem_data  = 8'h3C;
        mem_sel   = 1'b1;
        mem_valid = 1'b1;
        chk("comp_hi_ready", 32'(mem_ready), 32'(0));
        for (int k = 0; k < 3; k++) tick();
        chk("comp_hi_busy",   32'(busy), 32'(0));
        chk("comp_hi_ready2", 32'(mem_ready), 32'(0));
        comp = 1'b0;
        tick();
        chk("comp_lo_ready_sync", 32'(mem_ready), 32'(0));
        tick();
        accept_word("comp_lo", 8'h3C, 1'b1);
        finish_word("comp_lo", 8'h3C, 1'b1);

        // Watchdog while waiting in DATA.
        accept_word("wd_data", 8'h5F, 1'b0);
        for (int k = 0; k < int'(TIMEOUT) - 1; k++) tick();
        chk("wd_data_err_early", 32'(timeout_err), 32'(0));
        chk_data("wd_data_still", 8'h5F, 1'b0);
        tick();
        chk("wd_data_err", 32'(timeout_err), 32'(1));
        chk_null("wd_data_err");
        chk("wd_data_ready", 32'(mem_ready), 32'(0));
        chk("wd_data_busy",  32'(busy), 32'(1));
        mem_valid = 1'b1;
        comp = 1'b1;
        for (int k = 0; k < 2 * int'(TIMEOUT); k++) tick();
        comp = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("err_sticky", 32'(timeout_err), 32'(1));
        chk("err_ready",  32'(mem_ready), 32'(0));
        chk_null("err_sticky");
        do_reset("err_rst");

        // Watchdog while waiting in NULLW: NULLW entered SYNC+1 edges after comp rises.
        accept_word("wd_null", 8'hC3, 1'b1);
        comp = 1'b1;
        for (int k = 0; k < int'(SYNC + TIMEOUT); k++) tick();
        chk("wd_null_err_early", 32'(timeout_err), 32'(0));
        chk_null("wd_null_wait");
        tick();
        chk("wd_null_err", 32'(timeout_err), 32'(1));
        chk("wd_null_ready", 32'(mem_ready), 32'(0));
        do_reset("wd_null_rst");

        // Reset in the middle of DATA.
        accept_word("mid", 8'h96, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk_null("mid_rst");
        chk("mid_rst_ready", 32'(mem_ready), 32'(0));
        chk("mid_rst_busy",  32'(busy), 32'(0));
        do_reset("mid_rel");
        for (int k = 0; k < 4; k++) tick();
        chk_null("mid_no_stale");
        chk("mid_no_stale_busy", 32'(busy), 32'(0));

        accept_word("post", 8'h7E, 1'b1);
        finish_word("post", 8'h7E, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
